// File: rtl/cam_pkg.sv
// Shared constants, FSM state type and depth helper for the CAM match array.
package cam_pkg;

    localparam int CAM_ADDR_WIDTH = 8;
    localparam int CAM_DATA_WIDTH = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

    function automatic int cam_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/cam_entry.sv
// One CAM entry: key register, valid bit and combinational key comparator.
// The don't-care mask input exists only when CAM_MATCH_ARRAY_MASK_EN is defined.
module cam_entry #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_set,
    input  logic                  wr_clr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] search_key,
`ifdef CAM_MATCH_ARRAY_MASK_EN
    input  logic [DATA_WIDTH-1:0] search_mask,
`endif
    output logic                  hit
);

    logic [DATA_WIDTH-1:0] key;
    logic                  valid;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (wr_clr) begin
            valid <= 1'b0;
        end else if (wr_set) begin
            valid <= 1'b1;
        end
    end

    // NOTE: key storage is deliberately not reset; the valid bit alone qualifies it.
    always_ff @(posedge clk) begin
        if (wr_set) begin
            key <= wr_data;
        end
    end

`ifdef CAM_MATCH_ARRAY_MASK_EN
    assign hit = valid && (((key ^ search_key) & ~search_mask) == '0);
`else
    assign hit = valid && (key == search_key);
`endif

endmodule

// File: rtl/cam_match_array.sv
// CAM storage/compare front end: entry writes, flush walker and registered match vector.
// Optional don't-care search mask enabled by defining CAM_MATCH_ARRAY_MASK_EN.
module cam_match_array
    import cam_pkg::*;
#(
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
    parameter int DEPTH      = cam_depth(ADDR_WIDTH),
    parameter int DATA_WIDTH = CAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_clear,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  flush_req,
    output logic                  flush_busy,
    input  logic                  search_valid,
    input  logic [DATA_WIDTH-1:0] search_key,
`ifdef CAM_MATCH_ARRAY_MASK_EN
    input  logic [DATA_WIDTH-1:0] search_mask,
`endif
    output logic                  search_ready,
    output logic                  match_valid,
    output logic [DEPTH-1:0]      match_vec
);

    flush_state_t          state, state_next;
    logic [ADDR_WIDTH-1:0] idx, idx_next;
    logic                  wr_accept;
    logic                  search_accept;
    logic [DEPTH-1:0]      hits;

    assign flush_busy    = (state == FLUSH);
    assign wr_ready      = !flush_busy;
    assign search_ready  = !flush_busy;
    assign wr_accept     = wr_en && wr_ready;
    assign search_accept = search_valid && search_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_next = FLUSH;
                    idx_next   = '0;
                end
            end
            FLUSH: begin
                idx_next = idx + 1'b1;
                if (idx == '1) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic sel;
        assign sel = (wr_addr == ADDR_WIDTH'(i));

        cam_entry #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_entry (
            .clk         (clk),
            .reset       (reset),
            .wr_set      (wr_accept && !wr_clear && sel),
            .wr_clr      ((wr_accept && wr_clear && sel) || (flush_busy && idx == ADDR_WIDTH'(i))),
            .wr_data     (wr_data),
            .search_key  (search_key),
`ifdef CAM_MATCH_ARRAY_MASK_EN
            .search_mask (search_mask),
`endif
            .hit         (hits[i])
        );
    end

    // Compare runs on current contents, so a same-cycle write is not visible to the search.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_valid <= 1'b0;
            match_vec   <= '0;
        end else begin
            match_valid <= search_accept;
            if (search_accept) begin
                match_vec <= hits;
            end
        end
    end

endmodule

// File: tb/tb_cam_match_array.sv
// Directed self-checking bench for cam_match_array (ADDR_WIDTH=3, DATA_WIDTH=8).
module tb_cam_match_array;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic             wr_clear;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             wr_ready;
    logic             flush_req;
    logic             flush_busy;
    logic             search_valid;
    logic [DW-1:0]    search_key;
`ifdef CAM_MATCH_ARRAY_MASK_EN
    logic [DW-1:0]    search_mask;
`endif
    logic             search_ready;
    logic             match_valid;
    logic [DEPTH-1:0] match_vec;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cam_match_array #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_clear     (wr_clear),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .flush_req    (flush_req),
        .flush_busy   (flush_busy),
        .search_valid (search_valid),
        .search_key   (search_key),
`ifdef CAM_MATCH_ARRAY_MASK_EN
        .search_mask  (search_mask),
`endif
        .search_ready (search_ready),
        .match_valid  (match_valid),
        .match_vec    (match_vec)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en        = 1'b0;
        wr_clear     = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        flush_req    = 1'b0;
        search_valid = 1'b0;
        search_key   = '0;
    endtask

    task automatic write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic search(input string tag, input logic [DW-1:0] key, input logic [DEPTH-1:0] expected);
        search_valid = 1'b1;
        search_key   = key;
        step();
        search_valid = 1'b0;
        check({tag, "_valid"}, 32'(match_valid), 32'd1);
        check({tag, "_vec"}, 32'(match_vec), 32'(expected));
    endtask

    initial begin
        int busy_cycles;
        idle_inputs();
`ifdef CAM_MATCH_ARRAY_MASK_EN
        search_mask = '0;
`endif
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_match_valid", 32'(match_valid), 32'd0);
        check("rst_match_vec", 32'(match_vec), 32'h00);
        check("rst_flush_busy", 32'(flush_busy), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_search_ready", 32'(search_ready), 32'd1);

        search("empty_search", 8'h00, 8'h00);
        step();
        check("match_valid_pulse", 32'(match_valid), 32'd0);

        write(3'd2, 8'hA5);
        write(3'd6, 8'hA5);
        search("multi_match", 8'hA5, 8'h44);
        search("no_match", 8'h5A, 8'h00);
        step();
        check("idle_valid_low", 32'(match_valid), 32'd0);
        check("idle_vec_hold", 32'(match_vec), 32'h00);

        // Same-cycle write and search: the search sees the old contents.
        wr_en   = 1'b1;
        wr_addr = 3'd4;
        wr_data = 8'h3C;
        search("rbw_same_cycle", 8'h3C, 8'h00);
        wr_en = 1'b0;
        search("rbw_next_cycle", 8'h3C, 8'h10);

        wr_clear = 1'b1;
        write(3'd2, 8'h00);
        wr_clear = 1'b0;
        search("after_clear", 8'hA5, 8'h40);

        // Flush request coinciding with a write: the write lands, then gets flushed.
        flush_req = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 3'd5;
        wr_data   = 8'h99;
        step();
        flush_req = 1'b0;
        wr_en     = 1'b0;
        busy_cycles = 0;
        while (flush_busy && busy_cycles < 20) begin
            check("flush_wr_ready", 32'(wr_ready), 32'd0);
            check("flush_search_ready", 32'(search_ready), 32'd0);
            wr_en        = 1'b1;
            wr_addr      = 3'd1;
            wr_data      = 8'h77;
            search_valid = 1'b1;
            search_key   = 8'hA5;
            flush_req    = (busy_cycles == 3);
            step();
            check("flush_search_dropped", 32'(match_valid), 32'd0);
            busy_cycles++;
        end
        idle_inputs();
        check("flush_busy_cycles", 32'(busy_cycles), 32'd8);
        check("flush_done_busy", 32'(flush_busy), 32'd0);
        search("post_flush_a5", 8'hA5, 8'h00);
        search("post_flush_3c", 8'h3C, 8'h00);
        search("dropped_write", 8'h77, 8'h00);
        search("flushed_write", 8'h99, 8'h00);

        write(3'd0, 8'hA5);
        write(3'd7, 8'h3C);
        search("refill", 8'h3C, 8'h80);

        // Reset during the third flush cycle.
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        check("midflush_busy1", 32'(flush_busy), 32'd1);
        step();
        step();
        check("midflush_busy3", 32'(flush_busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midflush_reset_busy", 32'(flush_busy), 32'd0);
        check("midflush_reset_valid", 32'(match_valid), 32'd0);
        check("midflush_reset_vec", 32'(match_vec), 32'h00);
        search("post_reset_3c", 8'h3C, 8'h00);
        search("post_reset_a5", 8'hA5, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
